// File: rtl/capture_buffer_ctrl_pkg.sv
// rtl/capture_buffer_ctrl_pkg.sv - shared state encoding, default widths and I/Q packing order
package capture_buffer_ctrl_pkg;

   localparam int DEF_BUFFER_LENGTH = 16;
   localparam int DEF_INDEX_BITS    = 5;
   localparam int DEF_I_BITS        = 12;
   localparam int DEF_Q_BITS        = 12;

   // Buffer words are packed {I, Q}: I occupies the MSBs.
   localparam bit IQ_I_IN_MSBS = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL_REQ,
      ST_FILL_RESP,
      ST_DRAIN,
      ST_DONE,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/capture_out_reg.sv
// rtl/capture_out_reg.sv - one-entry valid/ready output register carrying the last flag
module capture_out_reg
   import capture_buffer_ctrl_pkg::*;
#(
   parameter int I_BITS = DEF_I_BITS,
   parameter int Q_BITS = DEF_Q_BITS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [I_BITS-1:0] load_i,
   input  logic [Q_BITS-1:0] load_q,
   input  logic              load_last,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [I_BITS-1:0] out_i,
   output logic [Q_BITS-1:0] out_q,
   output logic              out_last,
   output logic              can_accept
);

   // A load is only requested when the slot is empty or emptying this cycle.
   assign can_accept = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_i     <= '0;
         out_q     <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_i     <= load_i;
         out_q     <= load_q;
         out_last  <= load_last;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: rtl/capture_buffer_ctrl.sv
// rtl/capture_buffer_ctrl.sv - capture buffer fill/drain sequencer
// Optional continuous capture: CAPTURE_BUFFER_CTRL_AUTO_REARM_EN.
module capture_buffer_ctrl
   import capture_buffer_ctrl_pkg::*;
#(
   parameter int BUFFER_LENGTH = DEF_BUFFER_LENGTH,
   parameter int INDEX_BITS    = DEF_INDEX_BITS,
   parameter int I_BITS        = DEF_I_BITS,
   parameter int Q_BITS        = DEF_Q_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     samp_valid,
   input  logic [I_BITS-1:0]        samp_i,
   input  logic [Q_BITS-1:0]        samp_q,
   output logic                     samp_ready,
   output logic                     out_valid,
   output logic [I_BITS-1:0]        out_i,
   output logic [Q_BITS-1:0]        out_q,
   output logic                     out_last,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [INDEX_BITS-1:0]    m_axi_waddr,
   output logic [I_BITS+Q_BITS-1:0] m_axi_wdata,
   output logic                     m_axi_wvalid,
   input  logic                     s_axi_wready,
   input  logic                     s_axi_bvalid,
   input  logic                     s_axi_bresp,
   output logic                     m_axi_bready,
   output logic [INDEX_BITS-1:0]    m_axi_raddr,
   output logic                     m_axi_rvalid,
   output logic                     m_axi_rready,
   input  logic                     s_axi_rvalid,
   input  logic [I_BITS-1:0]        buf_i,
   input  logic [Q_BITS-1:0]        buf_q
);

   localparam logic [INDEX_BITS-1:0] LAST_ADDR = INDEX_BITS'(BUFFER_LENGTH - 1);

   state_t                   state, state_nxt;
   logic [INDEX_BITS-1:0]    waddr, raddr;
   logic [I_BITS+Q_BITS-1:0] wdata, samp_word;
   logic                     wvalid, rd_pend, rd_all;
   logic                     start_ok, samp_hs, w_hs, b_hs, b_ok, fill_last;
   logic                     rd_issue, rd_hs, last_hs, rearm, can_accept;

   assign samp_word = IQ_I_IN_MSBS ? {samp_i, samp_q} : {samp_q, samp_i};

   assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
   assign samp_hs   = (state == ST_FILL_REQ) && !wvalid && samp_valid;
   assign w_hs      = (state == ST_FILL_REQ) && wvalid && s_axi_wready;
   assign b_hs      = (state == ST_FILL_RESP) && s_axi_bvalid;
   assign b_ok      = b_hs && !s_axi_bresp;
   assign fill_last = (waddr == LAST_ADDR);
   // rd_all stops further reads once the final word has been fetched.
   assign rd_issue  = (state == ST_DRAIN) && !rd_pend && !rd_all && can_accept;
   assign rd_hs     = (state == ST_DRAIN) && rd_pend && s_axi_rvalid;
   assign last_hs   = (state == ST_DRAIN) && out_valid && out_ready && out_last;

`ifdef CAPTURE_BUFFER_CTRL_AUTO_REARM_EN
   logic done_q;
   always_ff @(posedge clk) begin
      if (!rst_n) done_q <= 1'b0;
      else        done_q <= last_hs;
   end
   assign rearm = last_hs;
   assign done  = done_q;
`else
   assign rearm = 1'b0;
   assign done  = (state == ST_DONE);
`endif

   always_comb begin
      state_nxt    = state;
      samp_ready   = 1'b0;
      busy         = 1'b0;
      error        = 1'b0;
      m_axi_bready = 1'b0;
      m_axi_rvalid = 1'b0;
      m_axi_rready = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) state_nxt = ST_FILL_REQ;
         end
         ST_ERROR: begin
            error = 1'b1;
            if (start) state_nxt = ST_FILL_REQ;
         end
         ST_FILL_REQ: begin
            busy       = 1'b1;
            samp_ready = !wvalid;
            if (w_hs) state_nxt = ST_FILL_RESP;
         end
         ST_FILL_RESP: begin
            busy         = 1'b1;
            m_axi_bready = 1'b1;
            if (b_hs) begin
               if (s_axi_bresp)    state_nxt = ST_ERROR;
               else if (fill_last) state_nxt = ST_DRAIN;
               else                state_nxt = ST_FILL_REQ;
            end
         end
         ST_DRAIN: begin
            busy         = 1'b1;
            m_axi_rvalid = rd_issue;
            m_axi_rready = rd_issue || rd_pend;
            if (last_hs) state_nxt = rearm ? ST_FILL_REQ : ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         waddr   <= '0;
         raddr   <= '0;
         wdata   <= '0;
         wvalid  <= 1'b0;
         rd_pend <= 1'b0;
         rd_all  <= 1'b0;
      end else begin
         state <= state_nxt;

         if (start_ok || rearm)              waddr <= '0;
         else if (b_ok && !fill_last)        waddr <= waddr + INDEX_BITS'(1);

         if (samp_hs) begin
            wdata  <= samp_word;
            wvalid <= 1'b1;
         end else if (w_hs) begin
            wvalid <= 1'b0;
         end

         if (b_ok && fill_last) begin
            raddr  <= '0;
            rd_all <= 1'b0;
         end else if (rd_hs) begin
            if (raddr == LAST_ADDR) rd_all <= 1'b1;
            else                    raddr  <= raddr + INDEX_BITS'(1);
         end

         if (rd_issue)   rd_pend <= 1'b1;
         else if (rd_hs) rd_pend <= 1'b0;
      end
   end

   assign m_axi_waddr  = waddr;
   assign m_axi_wdata  = wdata;
   assign m_axi_wvalid = wvalid;
   assign m_axi_raddr  = raddr;

   capture_out_reg #(
      .I_BITS (I_BITS),
      .Q_BITS (Q_BITS)
   ) u_out_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (rd_hs),
      .load_i     (buf_i),
      .load_q     (buf_q),
      .load_last  (raddr == LAST_ADDR),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_i      (out_i),
      .out_q      (out_q),
      .out_last   (out_last),
      .can_accept (can_accept)
   );

endmodule

// File: tb/tb_capture_buffer_ctrl.sv
// tb/tb_capture_buffer_ctrl.sv - self-checking bench for capture_buffer_ctrl
// Buffer responder and sample/output logs model the expected traffic; CAPTURE_BUFFER_CTRL_AUTO_REARM_EN adds a re-arm pass.
module tb_capture_buffer_ctrl;
   localparam int LEN = 16;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, samp_valid = 1'b0, out_ready = 1'b0;
   logic [11:0] samp_i = '0, samp_q = '0, buf_i = '0, buf_q = '0;
   logic        s_axi_wready = 1'b0, s_axi_bvalid = 1'b0, s_axi_bresp = 1'b0, s_axi_rvalid = 1'b0;
   logic        samp_ready, out_valid, out_last, busy, done, error;
   logic [11:0] out_i, out_q;
   logic [4:0]  m_axi_waddr, m_axi_raddr;
   logic [23:0] m_axi_wdata;
   logic        m_axi_wvalid, m_axi_bready, m_axi_rvalid, m_axi_rready;

   capture_buffer_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .samp_valid(samp_valid), .samp_i(samp_i), .samp_q(samp_q), .samp_ready(samp_ready),
      .out_valid(out_valid), .out_i(out_i), .out_q(out_q), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .done(done), .error(error),
      .m_axi_waddr(m_axi_waddr), .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bvalid(s_axi_bvalid), .s_axi_bresp(s_axi_bresp),
      .m_axi_bready(m_axi_bready), .m_axi_raddr(m_axi_raddr), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready), .s_axi_rvalid(s_axi_rvalid), .buf_i(buf_i), .buf_q(buf_q)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; logic [23:0] data; int cyc; } wr_t;
   typedef struct { logic [11:0] i; logic [11:0] q; logic last; int cyc; } out_t;
   wr_t  wr_log[$];
   out_t out_log[$];

   int n_assert = 0, n_fail = 0;
   int cyc = 0, rd_req_cnt = 0, done_cnt = 0;
   int stall_addr = -1, err_addr = -1, wr_wait = -1, r_wait = 0;
   bit wr_rand = 0, rd_rand = 0, b_pend = 0, b_err = 0, r_pend = 0;
   logic [4:0]  hold_addr = '0, r_addr = '0;
   logic [23:0] hold_data = '0;
   logic [23:0] mem [32];
   logic [11:0] exp_i [LEN];
   logic [11:0] exp_q [LEN];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Buffer model: write/response and read handshakes, plus output monitor.
   task automatic buffer_step();
      bit was_pend;
      s_axi_wready = 1'b0; s_axi_bvalid = 1'b0; s_axi_bresp = 1'b0; s_axi_rvalid = 1'b0;
      cyc++;
      if (done === 1'b1) done_cnt++;
      if (!rst_n) begin
         wr_wait = -1; b_pend = 0; r_pend = 0;
      end else begin
         if (b_pend) begin s_axi_bvalid = 1'b1; s_axi_bresp = b_err; b_pend = 0; end
         if (m_axi_wvalid) begin
            if (wr_wait < 0) begin
               wr_wait = (int'(m_axi_waddr) == stall_addr) ? 5 : (wr_rand ? int'($urandom_range(0, 2)) : 0);
               hold_addr = m_axi_waddr; hold_data = m_axi_wdata;
            end else begin
               chk("wr_hold_addr", 64'(m_axi_waddr), 64'(hold_addr));
               chk("wr_hold_data", 64'(m_axi_wdata), 64'(hold_data));
               chk("wr_hold_samp_ready", 64'(samp_ready), 64'(0));
            end
            if (wr_wait == 0) begin
               s_axi_wready = 1'b1;
               wr_log.push_back('{int'(m_axi_waddr), m_axi_wdata, cyc});
               mem[m_axi_waddr] = m_axi_wdata;
               b_pend = 1; b_err = (int'(m_axi_waddr) == err_addr);
               wr_wait = -1;
            end else wr_wait--;
         end
         was_pend = r_pend;
         if (r_pend) begin
            if (r_wait == 0) begin
               s_axi_rvalid = 1'b1; {buf_i, buf_q} = mem[r_addr]; r_pend = 0;
            end else r_wait--;
         end
         if (m_axi_rvalid) begin
            chk("rd_single_outstanding", 64'(was_pend), 64'(0));
            rd_req_cnt++; r_pend = 1; r_addr = m_axi_raddr;
            r_wait = rd_rand ? int'($urandom_range(0, 2)) : 0;
         end
         if (out_valid && out_ready) out_log.push_back('{out_i, out_q, out_last, cyc});
      end
   endtask

   initial forever begin
      @(negedge clk);
      buffer_step();
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(1); start = 1'b0;
   endtask

   task automatic gen(input bit pattern);
      for (int k = 0; k < LEN; k++) begin
         exp_i[k] = pattern ? 12'(k) : 12'($urandom);
         exp_q[k] = pattern ? 12'(-k) : 12'($urandom);
      end
      wr_log.delete(); out_log.delete();
   endtask

   task automatic send(input logic [11:0] i, input logic [11:0] q);
      int n = 0;
      samp_valid = 1'b1; samp_i = i; samp_q = q;
      @(negedge clk);
      while (!samp_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("samp_accept_timeout", 64'(samp_ready), 64'(1));
      @(posedge clk); #1;
      samp_valid = 1'b0;
   endtask

   task automatic send_all(input int n, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps) tick(int'($urandom_range(0, 2)));
         send(exp_i[k], exp_q[k]);
      end
   endtask

   task automatic drain(input bit rnd);
      int g = 0;
      while (done !== 1'b1 && g < 3000) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick(1); g++;
      end
      chk("done_seen", 64'(done), 64'(1));
      out_ready = 1'b1;
   endtask

   task automatic check_logs(input int n_wr, input int n_out);
      chk("wr_count", 64'(wr_log.size()), 64'(n_wr));
      for (int k = 0; k < n_wr && k < wr_log.size(); k++) begin
         chk("wr_addr", 64'(wr_log[k].addr), 64'(k));
         chk("wr_data", 64'(wr_log[k].data), 64'({exp_i[k], exp_q[k]}));
      end
      chk("out_count", 64'(out_log.size()), 64'(n_out));
      for (int k = 0; k < n_out && k < out_log.size(); k++) begin
         chk("out_i", 64'(out_log[k].i), 64'(exp_i[k]));
         chk("out_q", 64'(out_log[k].q), 64'(exp_q[k]));
         chk("out_last", 64'(out_log[k].last), 64'(k == LEN - 1));
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk(tag, 64'({samp_ready, out_valid, out_i, out_q, out_last, busy, done, error}), 64'(0));
      chk(tag, 64'({m_axi_waddr, m_axi_wdata, m_axi_wvalid, m_axi_bready,
                    m_axi_raddr, m_axi_rvalid, m_axi_rready}), 64'(0));
   endtask

   initial begin
      int g, rq, d0;
      // reset state
      tick(3);
      check_all_zero("reset_outputs");
      rst_n = 1'b1; tick(1);
      chk("idle_busy", 64'(busy), 64'(0));

      // basic ramp with zero-latency buffer: fill rate 3 cycles, drain rate 2 cycles
      gen(1); pulse_start();
      chk("start_busy", 64'(busy), 64'(1));
      send_all(LEN, 0); drain(0);
      chk("basic_busy_after", 64'(busy), 64'(0));
      check_logs(LEN, LEN);
      for (int k = 1; k < LEN && k < wr_log.size(); k++)
         chk("fill_rate", 64'(wr_log[k].cyc - wr_log[k-1].cyc), 64'(3));
      for (int k = 1; k < LEN && k < out_log.size(); k++)
         chk("drain_rate", 64'(out_log[k].cyc - out_log[k-1].cyc), 64'(2));

      // write backpressure on address 3
      gen(0); stall_addr = 3; pulse_start();
      send_all(LEN, 0); drain(0); stall_addr = -1;
      check_logs(LEN, LEN);

      // output backpressure at sample 7
      gen(0); pulse_start(); send_all(LEN, 0);
      out_ready = 1'b1; g = 0;
      while (out_log.size() < 7 && g < 500) begin tick(1); g++; end
      out_ready = 1'b0; g = 0;
      while (!out_valid && g < 50) begin tick(1); g++; end
      rq = rd_req_cnt;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         chk("hold_valid", 64'(out_valid), 64'(1));
         chk("hold_i", 64'(out_i), 64'(exp_i[7]));
         chk("hold_no_read", 64'(rd_req_cnt), 64'(rq));
      end
      drain(0);
      check_logs(LEN, LEN);

      // error response on address 5, then restart
      gen(0); err_addr = 5; pulse_start();
      send_all(6, 0); tick(3);
      chk("err_flag", 64'(error), 64'(1));
      chk("err_busy", 64'(busy), 64'(0));
      chk("err_samp_ready", 64'(samp_ready), 64'(0));
      chk("err_wr_count", 64'(wr_log.size()), 64'(6));
      err_addr = -1; gen(0); pulse_start();
      chk("restart_error", 64'(error), 64'(0));
      chk("restart_waddr", 64'(m_axi_waddr), 64'(0));
      send_all(LEN, 0); drain(0);
      check_logs(LEN, LEN);

      // randomized latencies, sample gaps and output ready
      wr_rand = 1; rd_rand = 1;
      for (int r = 0; r < 3; r++) begin
         gen(0); pulse_start(); send_all(LEN, 1); drain(1);
         check_logs(LEN, LEN);
      end
      wr_rand = 0; rd_rand = 0;

      // reset mid-drain, then a normal capture
      gen(0); pulse_start(); send_all(LEN, 0);
      out_ready = 1'b1; g = 0;
      while (out_log.size() < 5 && g < 500) begin tick(1); g++; end
      rst_n = 1'b0; tick(2);
      check_all_zero("mid_reset_outputs");
      rst_n = 1'b1; tick(1);
      chk("post_reset_idle", 64'({busy, done, error}), 64'(0));
      gen(0); pulse_start(); send_all(LEN, 0); drain(0);
      check_logs(LEN, LEN);

`ifdef CAPTURE_BUFFER_CTRL_AUTO_REARM_EN
      // two captures back to back, the second without start
      for (int r = 0; r < 2; r++) begin
         gen(0);
         if (r == 0) pulse_start();
         d0 = done_cnt;
         send_all(LEN, 0); drain(0); tick(2);
         chk("rearm_done_pulse", 64'(done_cnt - d0), 64'(1));
         chk("rearm_busy", 64'(busy), 64'(1));
         check_logs(LEN, LEN);
      end
`else
      d0 = done_cnt; tick(3);
      chk("done_held", 64'(done_cnt - d0), 64'(3));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
